pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

- Central stall/flush scheduler for the five-stage MIPS core.
- Drives the enable and clear inputs of the F/D/E/M/W pipeline registers (enable-and-clear flops) from four sources:
  - sram-like memory busy flags
  - load-use hazards
  - a multi-cycle divider
  - committed exceptions
- Owns the divider cycle counter.
- Holds a pending exception until no memory transaction is in flight, so the exception redirect never aborts a sram-like transfer.

## Interface
Parameters:
- DIV_CYCLES, 32, stall cycles per div/divu (must be ≥1)
- CNT_W, 6, counter width; DIV_CYCLES-1 must fit

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- inst_busy  in  1  instruction fetch not complete this cycle
- data_busy  in  1  M-stage data access not complete this cycle
- lu_hazard  in  1  load-use hazard on the instruction in D
- div_start  in  1  div/divu present in E
- except_req  in  1  exception/eret committed in M
- en_f, en_d, en_e, en_m, en_w  out  1 each  register enables
- flush_d, flush_e, flush_m, flush_w  out  1 each  synchronous clears (bubble insert)
- except_go  out  1  one-cycle pulse; PC loads handler/EPC
- div_busy  out  1  divider stall in progress

## Operation
State machine states:
- RUN
- DIV: counting
- XPEND: exception latched, waiting for memory

Counter:
- cnt (CNT_W bits), reset 0.

Stall chain, RUN/DIV, no exception:
- div_stall = (RUN & div_start) | (DIV & cnt≠0)
- stall_m = data_busy
- stall_e = stall_m | div_stall
- stall_d = stall_e | lu_hazard
- stall_f = stall_d | inst_busy
- en_x = !stall_x for f/d/e/m; en_w = 1

Bubbles:
- flush_d = inst_busy & !stall_d
- flush_e = lu_hazard & !stall_e
- flush_m = div_stall & !stall_m
- flush_w = data_busy

Divider:
- RUN & div_start & !except_req: cnt ← DIV_CYCLES-1, go DIV.
- DIV: cnt decrements each cycle, including during data_busy.
- At cnt==0: div_stall=0, E advances, go RUN.
- div_start is ignored outside RUN.
- div_busy = div_stall.

Exception, except_req is sampled only in RUN/DIV:
- If inst_busy=0 and data_busy=0, in the same cycle:
  - except_go=1
  - all en=1, flush_d/e/m/w=1
  - cnt ← 0, go RUN
- Otherwise go XPEND, cnt ← 0 (divide aborted).
  - Outputs this cycle: all en=0, all flush=0.

XPEND:
- All en=0, flushes 0, except_req ignored.
- Leaves on the first cycle with inst_busy=0 and data_busy=0.
  - That cycle: except_go=1, all en=1, all flushes=1, go RUN.

Precedence:
- Exception handling overrides every stall and bubble term.
- data_busy overrides div/lu/inst terms through the chain.

## Timing
- All outputs are combinational from state, cnt and inputs. There is no added latency.
- Reset (async, immediate): state RUN, cnt 0.
  - While rst=1: en_* = 0, flush_* = 1, except_go = 0, div_busy = 0.
- Divide: exactly DIV_CYCLES cycles with en_e=0, counted from the div_start cycle. E advances on cycle DIV_CYCLES+1.
- except_go is asserted for exactly one cycle per accepted exception. It is never asserted while inst_busy or data_busy is 1.
- Reset mid-DIV or mid-XPEND discards the divide or the exception.

## Test plan
- **Load-use:** lu_hazard=1 for 1 cycle, others 0 → en_f=en_d=0, en_e=1, flush_e=1; next cycle all en=1, no flush.
- **Divide, DIV_CYCLES=4:** div_start=1 held → en_e=0 for 4 cycles with flush_m=1 each, div_busy=1; cycle 5 en_e=1.
- **Divide with data_busy=1 on cycles 3–6:**
  - Cycles 3–6: flush_w=1, en_m=0, en_e=0.
  - Cycle 7: en_e=1.
  - The counter does not extend the stall beyond the memory stall.
- **Exception, idle memory:** except_req=1 → same cycle except_go=1, flush_d/e/m/w=1, en_*=1.
- **Exception with data_busy=1 for 3 cycles:**
  - 3 cycles: all en=0, except_go=0.
  - 4th cycle: except_go=1 and all flushes=1.
  - A second except_req during the wait produces no extra pulse.
- **Reset mid-DIV:** assert rst asynchronously at cnt=2 → outputs go to reset values immediately; after release, state RUN and div_busy=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline hazard sources and the stall/flush scheduler.
// The master side drives the busy/hazard/exception requests; the slave side is the scheduler.
interface pipe_stall_ctrl_if;
    logic inst_busy;
    logic data_busy;
    logic lu_hazard;
    logic div_start;
    logic except_req;
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
    logic except_go;
    logic div_busy;

    modport master (
        output inst_busy, data_busy, lu_hazard, div_start, except_req,
        input  en_f, en_d, en_e, en_m, en_w,
        input  flush_d, flush_e, flush_m, flush_w, except_go, div_busy
    );

    modport slave (
        input  inst_busy, data_busy, lu_hazard, div_start, except_req,
        output en_f, en_d, en_e, en_m, en_w,
        output flush_d, flush_e, flush_m, flush_w, except_go, div_busy
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the five-stage core: drives pipeline register enables and clears
// from memory busy, load-use, divider and exception sources; owns the divider cycle counter.
module pipe_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDiv, StXpend} state_e;

    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_run;
    logic w_div;
    logic w_xpend;
    logic w_idle;
    logic w_xtake;
    logic w_xfire;
    logic w_xhold;
    logic w_div_stall;
    logic w_stall_m;
    logic w_stall_e;
    logic w_stall_d;
    logic w_stall_f;

    assign w_run   = (r_state == StRun);
    assign w_div   = (r_state == StDiv);
    assign w_xpend = (r_state == StXpend);
    assign w_idle  = !bus.inst_busy && !bus.data_busy;

    // A new request is only sampled outside XPEND; a latched one fires once memory is idle.
    assign w_xtake = !w_xpend && bus.except_req;
    assign w_xfire = (w_xpend || w_xtake) && w_idle;
    assign w_xhold = (w_xpend || w_xtake) && !w_idle;

    assign w_div_stall = (w_run && bus.div_start) || (w_div && (r_cnt != '0));
    assign w_stall_m   = bus.data_busy;
    assign w_stall_e   = w_stall_m || w_div_stall;
    assign w_stall_d   = w_stall_e || bus.lu_hazard;
    assign w_stall_f   = w_stall_d || bus.inst_busy;

    always_comb begin
        bus.en_f      = !w_stall_f;
        bus.en_d      = !w_stall_d;
        bus.en_e      = !w_stall_e;
        bus.en_m      = !w_stall_m;
        bus.en_w      = 1'b1;
        bus.flush_d   = bus.inst_busy && !w_stall_d;
        bus.flush_e   = bus.lu_hazard && !w_stall_e;
        bus.flush_m   = w_div_stall && !w_stall_m;
        bus.flush_w   = bus.data_busy;
        bus.except_go = 1'b0;
        bus.div_busy  = w_div_stall;
        if (rst) begin
            bus.en_f      = 1'b0;
            bus.en_d      = 1'b0;
            bus.en_e      = 1'b0;
            bus.en_m      = 1'b0;
            bus.en_w      = 1'b0;
            bus.flush_d   = 1'b1;
            bus.flush_e   = 1'b1;
            bus.flush_m   = 1'b1;
            bus.flush_w   = 1'b1;
            bus.div_busy  = 1'b0;
        end else if (w_xfire) begin
            bus.en_f      = 1'b1;
            bus.en_d      = 1'b1;
            bus.en_e      = 1'b1;
            bus.en_m      = 1'b1;
            bus.en_w      = 1'b1;
            bus.flush_d   = 1'b1;
            bus.flush_e   = 1'b1;
            bus.flush_m   = 1'b1;
            bus.flush_w   = 1'b1;
            bus.except_go = 1'b1;
            bus.div_busy  = 1'b0;
        end else if (w_xhold) begin
            bus.en_f      = 1'b0;
            bus.en_d      = 1'b0;
            bus.en_e      = 1'b0;
            bus.en_m      = 1'b0;
            bus.en_w      = 1'b0;
            bus.flush_d   = 1'b0;
            bus.flush_e   = 1'b0;
            bus.flush_m   = 1'b0;
            bus.flush_w   = 1'b0;
            bus.div_busy  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StRun, StDiv: begin
                    if (bus.except_req) begin
                        r_cnt   <= '0;
                        r_state <= w_idle ? StRun : StXpend;
                    end else if (w_run) begin
                        if (bus.div_start) begin
                            r_cnt   <= DivLoad;
                            r_state <= StDiv;
                        end
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!bus.data_busy) begin
                        // Stay in DIV at zero until E can actually advance, or the held
                        // div_start would relaunch the divide.
                        r_state <= StRun;
                    end
                end
                StXpend: begin
                    if (w_idle) begin
                        r_state <= StRun;
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed test-plan sequences plus random stimulus
// compared each cycle against a cycle-count reference model.
module tb_pipe_stall_ctrl;

    localparam int unsigned D = 4;

    // {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m,flush_w, except_go, div_busy}
    localparam logic [10:0] VecRst  = 11'b00000_1111_00;
    localparam logic [10:0] VecIdle = 11'b11111_0000_00;
    localparam logic [10:0] VecGo   = 11'b11111_1111_10;
    localparam logic [10:0] VecHold = 11'b00000_0000_00;
    localparam logic [10:0] VecDiv  = 11'b00011_0010_01;
    localparam logic [10:0] VecLu   = 11'b00111_0100_00;

    logic clk;
    logic rst;
    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .DIV_CYCLES (D),
        .CNT_W      (6)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [10:0] w_out;
    assign w_out = {bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_w,
                    bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w,
                    bus.except_go, bus.div_busy};

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] r_last;

    // Reference model: pending-exception flag, divide-active flag and cycles since div_start.
    bit m_xpend;
    bit m_in_div;
    int m_el;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_out(input bit ib, input bit db, input bit lu,
                                              input bit ds, input bit er);
        bit idle;
        bit dstall;
        bit sm, se, sd, sf;
        idle = !ib && !db;
        if (m_xpend || er) return idle ? VecGo : VecHold;
        dstall = m_in_div ? (m_el < int'(D)) : ds;
        sm = db;
        se = sm || dstall;
        sd = se || lu;
        sf = sd || ib;
        return {!sf, !sd, !se, !sm, 1'b1, ib && !sd, lu && !se, dstall && !sm, db, 1'b0, dstall};
    endfunction

    task automatic model_update(input bit ib, input bit db, input bit ds, input bit er);
        bit idle;
        idle = !ib && !db;
        if (m_xpend) begin
            if (idle) m_xpend = 1'b0;
        end else if (er) begin
            m_in_div = 1'b0;
            m_xpend  = !idle;
        end else if (m_in_div) begin
            if (m_el >= int'(D) && !db) m_in_div = 1'b0;
            else m_el++;
        end else if (ds) begin
            m_in_div = 1'b1;
            m_el     = 1;
        end
    endtask

    task automatic model_reset();
        m_xpend  = 1'b0;
        m_in_div = 1'b0;
        m_el     = 0;
    endtask

    task automatic drive(input bit ib, input bit db, input bit lu, input bit ds, input bit er);
        bus.inst_busy  = ib;
        bus.data_busy  = db;
        bus.lu_hazard  = lu;
        bus.div_start  = ds;
        bus.except_req = er;
    endtask

    // Called 1 time unit after a rising edge; samples mid-cycle and returns after the next edge.
    task automatic step(input string tag, input bit ib, input bit db, input bit lu,
                        input bit ds, input bit er);
        drive(ib, db, lu, ds, er);
        #3;
        r_last = w_out;
        check(tag, r_last, model_out(ib, db, lu, ds, er));
        model_update(ib, db, ds, er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #3;
        check("reset_vals", w_out, VecRst);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("idle", 0, 0, 0, 0, 0);
        check("idle_c", r_last, VecIdle);

        step("lu", 0, 0, 1, 0, 0);
        check("lu_c", r_last, VecLu);
        step("lu_after", 0, 0, 0, 0, 0);
        check("lu_after_c", r_last, VecIdle);

        for (int i = 0; i < int'(D); i++) begin
            step("div", 0, 0, 0, 1, 0);
            check("div_c", r_last, VecDiv);
        end
        step("div_end", 0, 0, 0, 1, 0);
        check("div_end_c", r_last, VecIdle);
        step("div_drop", 0, 0, 0, 0, 0);
        check("div_drop_c", r_last, VecIdle);

        for (int c = 1; c <= 7; c++) begin
            step("divdb", 0, (c >= 3 && c <= 6), 0, 1, 0);
            if (c >= 3 && c <= 6) check("divdb_stall", r_last & 11'b00110_0001_00,
                                        11'b00000_0001_00);
        end
        check("divdb_adv", r_last, VecIdle);
        step("divdb_drop", 0, 0, 0, 0, 0);

        step("exc_idle", 0, 0, 0, 0, 1);
        check("exc_idle_c", r_last, VecGo);
        step("exc_idle_after", 0, 0, 0, 0, 0);

        step("xp1", 0, 1, 0, 0, 1);
        check("xp1_c", r_last, VecHold);
        step("xp2", 0, 1, 0, 0, 0);
        check("xp2_c", r_last, VecHold);
        step("xp3", 0, 1, 0, 0, 1);
        check("xp3_c", r_last, VecHold);
        step("xp_go", 0, 0, 0, 0, 0);
        check("xp_go_c", r_last, VecGo);
        step("xp_after", 0, 0, 0, 0, 0);
        check("xp_after_c", r_last, VecIdle);

        step("rdiv0", 0, 0, 0, 1, 0);
        step("rdiv1", 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", w_out, VecRst);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 0, 0, 0, 0, 0);
        check("post_rst_c", r_last, VecIdle);

        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
